// File: rtl/echo_delay.sv
// Echo/delay effect: two-stage sample pipeline over a cleared delay line.
// Single echo or recirculating feedback, with saturating mix.
module echo_delay #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] in,
  input  logic             toggle_en,
  input  logic             feedback,
  input  logic [AW-1:0]    delay_len,
  input  logic [2:0]       fb_shift,
  output logic [WIDTH-1:0] out,
  output logic             valid_out,
  output logic             enabled,
  output logic             busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_n;
  logic [AW-1:0]    clr_cnt, clr_cnt_n;
  logic             enabled_n;
  logic [AW-1:0]    wr_ptr;

  logic             s1_valid, s1_fb, s1_en;
  logic [WIDTH-1:0] s1_in;
  logic [2:0]       s1_sh;
  logic [AW-1:0]    s1_dl;

  logic             s2_valid, s2_fb, s2_en;
  logic [WIDTH-1:0] s2_in;
  logic [2:0]       s2_sh;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q, fwd_q, dly;
  logic             fwd_hit;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wet, res, st_wd, mem_wd;
  logic             run, st_we, mem_we;
  logic [AW-1:0]    mem_wa, rd_addr, dl_eff;

  assign busy = (state == CLEAR);
  assign run  = (state == RUN);

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    enabled_n = enabled;
    if (state == CLEAR) begin
      clr_cnt_n = clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1))
        state_n = RUN;
    end
    // Turning the effect on always restarts a full clear.
    if (toggle_en) begin
      enabled_n = ~enabled;
      if (!enabled) begin
        state_n   = CLEAR;
        clr_cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      enabled <= 1'b0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      enabled <= enabled_n;
    end
  end

  assign dly    = fwd_hit ? fwd_q : rd_q;
  assign sum    = {1'b0, s2_in} + {1'b0, dly >> s2_sh};
  assign wet    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign res    = (s2_en && run) ? wet : s2_in;
  assign st_we  = s2_valid && run;
  assign st_wd  = !s2_en ? '0 : (s2_fb ? res : s2_in);
  assign mem_we = busy || st_we;
  assign mem_wa = busy ? clr_cnt : wr_ptr;
  assign mem_wd = busy ? '0 : st_wd;

  // Read relative to where this sample itself will be written.
  assign dl_eff  = (s1_dl == '0) ? AW'(1) : s1_dl;
  assign rd_addr = wr_ptr + AW'(st_we) - dl_eff;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
    if (s1_valid) begin
      rd_q    <= mem[rd_addr];
      fwd_hit <= mem_we && (mem_wa == rd_addr);
      fwd_q   <= mem_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_fb     <= 1'b0;
      s1_en     <= 1'b0;
      s1_in     <= '0;
      s1_sh     <= '0;
      s1_dl     <= '0;
      s2_valid  <= 1'b0;
      s2_fb     <= 1'b0;
      s2_en     <= 1'b0;
      s2_in     <= '0;
      s2_sh     <= '0;
      valid_out <= 1'b0;
      out       <= '0;
      wr_ptr    <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_in <= in;
        s1_fb <= feedback;
        s1_sh <= fb_shift;
        s1_dl <= delay_len;
        s1_en <= enabled;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_in <= s1_in;
        s2_fb <= s1_fb;
        s2_sh <= s1_sh;
        s2_en <= s1_en;
      end
      valid_out <= s2_valid;
      if (s2_valid)
        out <= res;
      if (st_we)
        wr_ptr <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// Bench for echo_delay: directed echo cases plus random samples
// against a sample-history reference model.
module tb_echo_delay;
  localparam int W = 12;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic         toggle_en = 1'b0;
  logic         feedback = 1'b0;
  logic [W-1:0] in_s = '0;
  logic [3:0]   delay_len = '0;
  logic [2:0]   fb_shift = '0;
  logic [W-1:0] out_s;
  logic         valid_out, enabled, busy;

  echo_delay #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in(in_s),
    .toggle_en(toggle_en), .feedback(feedback),
    .delay_len(delay_len), .fb_shift(fb_shift), .out(out_s),
    .valid_out(valid_out), .enabled(enabled), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample-indexed history since the last clear: entry k is what
  // the k-th processed sample left in the delay line.
  bit m_en = 1'b0;
  int hist [4096];
  int hn = 0;

  typedef struct { int due; int val; } exp_t;
  exp_t exp_q[$];
  int   obs[$];

  function automatic int model(int x, bit fb, int dl, int sh);
    int d, dly, s, o;
    d   = (dl == 0) ? 1 : dl;
    dly = (hn - d >= 0) ? hist[hn - d] : 0;
    s   = x + (dly >> sh);
    o   = m_en ? ((s > 4095) ? 4095 : s) : x;
    hist[hn] = m_en ? (fb ? o : x) : 0;
    hn++;
    return o;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (valid_in && !reset) begin
      e.due = cyc + 2;
      e.val = model(in_s, feedback, delay_len, fb_shift);
      exp_q.push_back(e);
    end
    #1;
    if (valid_out) begin
      obs.push_back(out_s);
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc, e.due);
        chk("out", out_s, e.val);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk("missing_valid", 0, 1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic send(int x, bit fb, int dl, int sh);
    valid_in  = 1'b1;
    in_s      = W'(x);
    feedback  = fb;
    delay_len = 4'(dl);
    fb_shift  = 3'(sh);
    step();
    valid_in  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  task automatic count_clear(output int n, output bit quiet);
    n = 0;
    quiet = 1'b1;
    do begin
      step();
      n++;
      if (valid_out || out_s != 0) quiet = 1'b0;
    end while (busy && n < 200);
  endtask

  function automatic int at(int i);
    return (i < obs.size()) ? obs[i] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit q;
    int x1, x2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_enabled", enabled, 0);
    chk("rst_out", out_s, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 1);

    reset = 1'b0;
    count_clear(n, q);
    chk("clear_cycles", n, D);
    chk("clear_quiet", q, 1);
    hn = 0;

    obs.delete();
    send('h123, 0, 4, 1);
    send('h456, 0, 4, 1);
    drain();
    chk("dry0", at(0), 'h123);
    chk("dry1", at(1), 'h456);
    chk("dry_count", obs.size(), 2);

    toggle_en = 1'b1;
    step();
    toggle_en = 1'b0;
    m_en = 1'b1;
    chk("enabled_on", enabled, 1);
    count_clear(n, q);
    chk("enable_clear", n, D);
    hn = 0;

    obs.delete();
    send('h800, 0, 4, 1);
    repeat (19) send(0, 0, 4, 1);
    drain();
    chk("imp_n0", at(0), 'h800);
    chk("imp_n3", at(3), 0);
    chk("imp_n4", at(4), 'h400);
    chk("imp_n8", at(8), 0);
    chk("imp_count", obs.size(), 20);

    obs.delete();
    send('h800, 1, 4, 1);
    repeat (23) send(0, 1, 4, 1);
    drain();
    chk("fb_n0", at(0), 'h800);
    chk("fb_n4", at(4), 'h400);
    chk("fb_n8", at(8), 'h200);
    chk("fb_n12", at(12), 'h100);
    chk("fb_n16", at(16), 'h080);

    obs.delete();
    repeat (8) send('hC00, 1, 1, 0);
    drain();
    chk("sat_n0", at(0), 'hC00);
    chk("sat_n1", at(1), 'hFFF);
    chk("sat_n7", at(7), 'hFFF);

    repeat (400) begin
      valid_in  = ($urandom_range(3) != 0);
      in_s      = W'($urandom);
      feedback  = 1'($urandom);
      delay_len = 4'($urandom);
      fb_shift  = 3'($urandom);
      step();
    end
    valid_in = 1'b0;
    drain();
    chk("rand_pending", exp_q.size(), 0);

    repeat (3) send($urandom_range(4095), 1, 2, 1);
    chk("pre_reset_valid", valid_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_enabled", enabled, 0);
    exp_q.delete();
    m_en = 1'b0;
    step();
    step();
    reset = 1'b0;
    count_clear(n, q);
    chk("rerun_clear", n, D);
    hn = 0;

    x1 = $urandom_range(4095);
    x2 = $urandom_range(4095);
    obs.delete();
    toggle_en = 1'b1;
    send(x1, 1, 1, 0);
    toggle_en = 1'b0;
    m_en = 1'b1;
    count_clear(n, q);
    chk("toggle_clear", n, D);
    hn = 0;
    send(x2, 1, 1, 0);
    drain();
    chk("toggle_dry", at(0), x1);
    chk("first_wet", at(1), x2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/echo_delay.md
ECHO_DELAY -- requirements
Module: echo_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample width in bits (unsigned samples).
REQ-002 SHALL have parameter DEPTH, default 1024, delay-line entries; power of two, >= 4; AW = log2(DEPTH).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port valid_in  input  1  sample strobe; in is sampled when high.
REQ-007 SHALL have port in  input  WIDTH  input sample.
REQ-008 SHALL have port toggle_en  input  1  single-cycle pulse; inverts enabled.
REQ-009 SHALL have port feedback  input  1  0 = single echo (delay line stores in); 1 = recirculating (delay line stores out).
REQ-010 SHALL have port delay_len  input  AW  echo delay in samples; 0 treated as 1.
REQ-011 SHALL have port fb_shift  input  3  echo attenuation; echo term = delayed sample >> fb_shift.
REQ-012 SHALL have port out  output  WIDTH  output sample.
REQ-013 SHALL have port valid_out  output  1  out is valid this cycle.
REQ-014 SHALL have port enabled  output  1  effect-enabled state.
REQ-015 SHALL have port busy  output  1  delay-line clear in progress.

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; CLEAR writes 0 to every entry, one per cycle, via a clear counter 0..DEPTH-1, then enters RUN.
REQ-017 SHALL enter CLEAR on reset release and whenever enabled changes 0->1; busy SHALL equal (state == CLEAR).
REQ-018 SHALL process samples in a 2-stage pipeline: valid_in at edge t yields valid_out high for exactly one cycle after edge t+2, one output per input, no drops, back-to-back valid_in accepted every cycle.
REQ-019 Stage 1 SHALL register in, feedback, fb_shift and issue the read at address wr_ptr - delay_len (mod DEPTH).
REQ-020 Stage 2 SHALL compute sum = in + (delayed >> fb_shift) at WIDTH+1 bits and saturate to 2^WIDTH-1 on overflow.
REQ-021 When enabled = 1 and state = RUN, out SHALL be the saturated sum; otherwise out SHALL equal in (dry passthrough, same 2-cycle latency).
REQ-022 On each stage-2 valid in RUN, SHALL write at wr_ptr: in if feedback = 0, out if feedback = 1, 0 if enabled = 0; then wr_ptr increments mod DEPTH (wrap DEPTH-1 -> 0).
REQ-023 wr_ptr SHALL not advance during CLEAR; CLEAR writes take the memory port, and stage-2 writes are discarded during CLEAR.
REQ-024 SHALL forward the stage-2 write data to stage 1 when the read address equals the address being written that cycle (delay_len = 1, back-to-back valid).
REQ-025 delay_len, feedback, fb_shift SHALL be sampled per sample in stage 1; changes take effect on the next accepted sample.
REQ-026 toggle_en simultaneous with valid_in: the sample entering stage 1 that cycle uses the old enabled value.
REQ-027 toggle_en during CLEAR: enabled inverts; a 0->1 change restarts the clear counter at 0; a 1->0 change lets the current CLEAR complete.
REQ-028 Memory SHALL be inferable as single-clock simple dual-port RAM (one write, one synchronous read per cycle).

Reset
REQ-029 While reset is high: enabled = 0, out = 0, valid_out = 0, wr_ptr = 0, pipeline valids = 0, state = CLEAR with counter = 0, busy = 1.
REQ-030 Reset asserted mid-operation SHALL discard in-flight samples immediately (valid_out low the same cycle, asynchronously).
REQ-031 Delay-line contents need no reset; CLEAR guarantees zeros before any wet output.

Verification (WIDTH=12, DEPTH=16)
REQ-032 Release reset, valid_in held low -> busy high exactly 16 cycles then low; out = 0, valid_out = 0 throughout.
REQ-033 Disabled, valid_in each cycle with in = 0x123, 0x456 -> out = 0x123, 0x456 two cycles after each, valid_out pulses one-for-one.
REQ-034 Enable, await busy low, feedback=0, delay_len=4, fb_shift=1, impulse in=0x800 then zeros -> out 0x800, 0,0,0, 0x400, then 0.
REQ-035 Same with feedback=1 -> out 0x800 at n=0, 0x400 at n=4, 0x200 at n=8, 0x100 at n=12, halving each 4 samples to 0.
REQ-036 feedback=1, fb_shift=0, delay_len=1, in=0xC00 every cycle -> second output = 0xFFF (saturated), forwarding exercised, remains 0xFFF.
REQ-037 Assert reset while valid samples in flight and busy low -> valid_out drops immediately; after release busy high 16 cycles; first output after enable equals dry in.
